// File: rtl/tpu_operand_mem_if.sv
// rtl/tpu_operand_mem_if.sv - load/read/host-write bundle for tpu_operand_mem
// master = control unit and host side, slave = operand memory.
interface tpu_operand_mem_if #(
   parameter int DATA_W = 8
);
   logic              load_signal;
   logic [3:0]        mem_addr;
   logic              wr_en;
   logic [3:0]        wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              addr_err;
   logic              wr_err;
   logic              busy;
   logic              burst_done;
   logic [4:0]        burst_len;

   modport master (
      output load_signal, mem_addr, wr_en, wr_addr, wr_data,
      input  rd_data, rd_valid, addr_err, wr_err, busy, burst_done, burst_len
   );

   modport slave (
      input  load_signal, mem_addr, wr_en, wr_addr, wr_data,
      output rd_data, rd_valid, addr_err, wr_err, busy, burst_done, burst_len
   );
endinterface

// File: rtl/tpu_operand_mem.sv
// rtl/tpu_operand_mem.sv - operand memory with 1-cycle reads and burst length tracking
// Host writes are only taken while idle; addresses >= DEPTH read as zero and flag addr_err.
module tpu_operand_mem #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) (
   input logic               clk,
   input logic               rst,
   tpu_operand_mem_if.slave  bus
);
   typedef enum logic {
      S_IDLE  = 1'b0,
      S_BURST = 1'b1
   } state_e;

   localparam logic [4:0] DEPTH_L = 5'(DEPTH);
   localparam logic [4:0] CNT_MAX = 5'd31;

   state_e            state_q, state_d;
   logic [4:0]        beat_cnt_q, beat_cnt_d;
   logic [4:0]        burst_len_q, burst_len_d;
   logic              burst_done_q, burst_done_d;
   logic              busy_q, busy_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;
   logic              addr_err_q, addr_err_d;
   logic              wr_err_q, wr_err_d;

   // Full 4-bit address space is allocated; entries >= DEPTH are never written.
   logic [DATA_W-1:0] mem_q [16];
   logic [DATA_W-1:0] mem_d [16];

   logic rd_in_range;
   logic wr_in_range;
   logic wr_accept;

   assign rd_in_range = ({1'b0, bus.mem_addr} < DEPTH_L);
   assign wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_L);

   always_comb begin
      state_d      = state_q;
      beat_cnt_d   = beat_cnt_q;
      burst_len_d  = burst_len_q;
      burst_done_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.load_signal) begin
               state_d    = S_BURST;
               beat_cnt_d = 5'd1;
            end
         end
         S_BURST: begin
            if (bus.load_signal) begin
               if (beat_cnt_q != CNT_MAX) begin
                  beat_cnt_d = beat_cnt_q + 5'd1;
               end
            end else begin
               state_d      = S_IDLE;
               burst_done_d = 1'b1;
               burst_len_d  = beat_cnt_q;
               beat_cnt_d   = 5'd0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d == S_BURST);
   end

   always_comb begin
      rd_valid_d = bus.load_signal;
      addr_err_d = bus.load_signal && !rd_in_range;
      rd_data_d  = rd_data_q;
      if (bus.load_signal) begin
         rd_data_d = rd_in_range ? mem_q[bus.mem_addr] : '0;
      end
   end

   // A write competing with a load or an open burst loses and is reported.
   always_comb begin
      wr_err_d  = bus.wr_en && (bus.load_signal || (state_q == S_BURST));
      wr_accept = bus.wr_en && !bus.load_signal && (state_q == S_IDLE) && wr_in_range;
      mem_d     = mem_q;
      if (wr_accept) begin
         mem_d[bus.wr_addr] = bus.wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         beat_cnt_q   <= 5'd0;
         burst_len_q  <= 5'd0;
         burst_done_q <= 1'b0;
         busy_q       <= 1'b0;
         rd_data_q    <= '0;
         rd_valid_q   <= 1'b0;
         addr_err_q   <= 1'b0;
         wr_err_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         beat_cnt_q   <= beat_cnt_d;
         burst_len_q  <= burst_len_d;
         burst_done_q <= burst_done_d;
         busy_q       <= busy_d;
         rd_data_q    <= rd_data_d;
         rd_valid_q   <= rd_valid_d;
         addr_err_q   <= addr_err_d;
         wr_err_q     <= wr_err_d;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 16; i++) begin
         mem_q[i] <= rst ? '0 : mem_d[i];
      end
   end

   assign bus.rd_data    = rd_data_q;
   assign bus.rd_valid   = rd_valid_q;
   assign bus.addr_err   = addr_err_q;
   assign bus.wr_err     = wr_err_q;
   assign bus.busy       = busy_q;
   assign bus.burst_done = burst_done_q;
   assign bus.burst_len  = burst_len_q;
endmodule

// File: tb/tb_tpu_operand_mem.sv
// tb/tb_tpu_operand_mem.sv - scoreboard bench for tpu_operand_mem at DEPTH 16 and 12
// Both instances see identical stimulus; each has its own reference model state.
module tb_tpu_operand_mem;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   tpu_operand_mem_if #(.DATA_W(8)) bus16 ();
   tpu_operand_mem_if #(.DATA_W(8)) bus12 ();

   tpu_operand_mem #(.DATA_W(8), .DEPTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
   tpu_operand_mem #(.DATA_W(8), .DEPTH(12)) dut12 (.clk(clk), .rst(rst), .bus(bus12));

   typedef struct {
      int         dut;
      logic [7:0] rd_data;
      logic       rd_valid;
      logic       addr_err;
      logic       wr_err;
      logic       busy;
      logic       burst_done;
      logic [4:0] burst_len;
   } exp_t;

   exp_t exp_q[$];
   int   tests  = 0;
   int   failed = 0;

   int         depth_c [2] = '{16, 12};
   logic [7:0] m_mem   [2][16];
   bit         m_burst [2];
   int         m_cnt   [2];
   int         m_len   [2];
   logic [7:0] m_rd    [2];

   task automatic check(input string nm, input int d, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s depth%0d: got %0h expected %0h at %0t", nm, depth_c[d], act, exp, $time);
      end
   endtask

   // Apply one cycle of stimulus to both instances and queue what each should show after the edge.
   task automatic step(input bit r, input bit ld, input logic [3:0] a, input bit we,
                       input logic [3:0] wa, input logic [7:0] wd);
      exp_t e [2];
      rst = r;
      bus16.load_signal = ld; bus16.mem_addr = a; bus16.wr_en = we; bus16.wr_addr = wa; bus16.wr_data = wd;
      bus12.load_signal = ld; bus12.mem_addr = a; bus12.wr_en = we; bus12.wr_addr = wa; bus12.wr_data = wd;
      for (int d = 0; d < 2; d++) begin
         e[d].dut = d;
         if (r) begin
            for (int k = 0; k < 16; k++) m_mem[d][k] = 8'h00;
            m_burst[d] = 1'b0;
            m_cnt[d]   = 0;
            m_len[d]   = 0;
            m_rd[d]    = 8'h00;
            e[d].rd_valid   = 1'b0;
            e[d].addr_err   = 1'b0;
            e[d].wr_err     = 1'b0;
            e[d].burst_done = 1'b0;
         end else begin
            e[d].rd_valid = ld;
            e[d].addr_err = ld && (int'(a) >= depth_c[d]);
            if (ld) m_rd[d] = (int'(a) < depth_c[d]) ? m_mem[d][a] : 8'h00;
            e[d].wr_err = we && (ld || m_burst[d]);
            if (we && !ld && !m_burst[d] && int'(wa) < depth_c[d]) m_mem[d][wa] = wd;
            e[d].burst_done = 1'b0;
            if (ld) begin
               m_cnt[d]   = m_burst[d] ? ((m_cnt[d] + 1 > 31) ? 31 : m_cnt[d] + 1) : 1;
               m_burst[d] = 1'b1;
            end else if (m_burst[d]) begin
               e[d].burst_done = 1'b1;
               m_len[d]   = m_cnt[d];
               m_cnt[d]   = 0;
               m_burst[d] = 1'b0;
            end
         end
         e[d].rd_data   = m_rd[d];
         e[d].busy      = m_burst[d];
         e[d].burst_len = 5'(m_len[d]);
      end
      @(posedge clk);
      #1;
      exp_q.push_back(e[0]);
      exp_q.push_back(e[1]);
   endtask

   always @(negedge clk) begin
      while (exp_q.size() > 0) begin
         exp_t e;
         logic [7:0] a_rd;
         logic [4:0] a_len;
         logic a_v, a_ae, a_we, a_busy, a_done;
         e = exp_q.pop_front();
         if (e.dut == 0) begin
            a_rd = bus16.rd_data; a_v = bus16.rd_valid; a_ae = bus16.addr_err; a_we = bus16.wr_err;
            a_busy = bus16.busy; a_done = bus16.burst_done; a_len = bus16.burst_len;
         end else begin
            a_rd = bus12.rd_data; a_v = bus12.rd_valid; a_ae = bus12.addr_err; a_we = bus12.wr_err;
            a_busy = bus12.busy; a_done = bus12.burst_done; a_len = bus12.burst_len;
         end
         check("rd_data",    e.dut, a_rd,           e.rd_data);
         check("rd_valid",   e.dut, {7'd0, a_v},    {7'd0, e.rd_valid});
         check("addr_err",   e.dut, {7'd0, a_ae},   {7'd0, e.addr_err});
         check("wr_err",     e.dut, {7'd0, a_we},   {7'd0, e.wr_err});
         check("busy",       e.dut, {7'd0, a_busy}, {7'd0, e.busy});
         check("burst_done", e.dut, {7'd0, a_done}, {7'd0, e.burst_done});
         check("burst_len",  e.dut, {3'd0, a_len},  {3'd0, e.burst_len});
      end
   end

   task automatic idle();
      step(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 8'h00);
   endtask

   task automatic beat(input logic [3:0] a);
      step(1'b0, 1'b1, a, 1'b0, 4'd0, 8'h00);
   endtask

   initial begin
      int waits;
      step(1'b1, 1'b1, 4'd3, 1'b1, 4'd3, 8'hFF);
      step(1'b1, 1'b1, 4'd4, 1'b1, 4'd4, 8'hEE);
      for (int i = 0; i < 16; i++) beat(4'(i));
      idle();

      for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 4'd0, 1'b1, 4'(i), 8'(8'hA0 + i));
      for (int i = 0; i < 4; i++) beat(4'(i));
      idle();

      beat(4'd11); beat(4'd12); beat(4'd15);
      idle();

      step(1'b0, 1'b1, 4'd5, 1'b1, 4'd5, 8'h55);
      idle();
      beat(4'd5);
      step(1'b0, 1'b0, 4'd0, 1'b1, 4'd6, 8'h66);
      idle();

      for (int i = 0; i < 40; i++) beat(4'($urandom_range(0, 15)));
      idle();
      beat(4'd1); idle(); beat(4'd2); beat(4'd3); idle();

      beat(4'd0); beat(4'd1); beat(4'd2);
      step(1'b1, 1'b1, 4'd3, 1'b0, 4'd0, 8'h00);
      idle();
      for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 4'd0, 1'b1, 4'(i), 8'(8'hA0 + i));
      beat(4'd7); beat(4'd8);
      idle();

      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
      end
      idle();
      idle();

      waits = 0;
      while (exp_q.size() > 0 && waits < 10) begin
         @(posedge clk);
         waits++;
      end
      if (exp_q.size() > 0) begin
         failed++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule

// File: doc/tpu_operand_mem.md
# tpu_operand_mem

Operand memory that answers load requests from the TPU control unit. The controller drives a load strobe and a 4-bit address; this block returns the addressed word one cycle later with a valid flag, tracks each load burst, and reports its length when the burst ends. A host write port fills the memory between runs; host writes during a burst are rejected and flagged.

## Interface
Parameters:
- DATA_W, 8, width of each stored word
- DEPTH, 16, number of implemented entries (1..16); addresses >= DEPTH are out of range

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- load_signal  in  1  load request strobe from the control unit, one beat per cycle while high
- mem_addr  in  4  read address, sampled with load_signal
- wr_en  in  1  host write strobe
- wr_addr  in  4  host write address
- wr_data  in  DATA_W  host write data
- rd_data  out  DATA_W  registered read data
- rd_valid  out  1  rd_data holds a response to the previous cycle's beat
- addr_err  out  1  previous cycle's beat addressed an entry >= DEPTH
- wr_err  out  1  previous cycle's host write was rejected
- busy  out  1  block is in BURST state
- burst_done  out  1  one-cycle pulse at the end of a burst
- burst_len  out  5  beats in the last completed burst, held until the next burst_done

## Operation
- Reset: all memory entries cleared to 0; rd_data=0, rd_valid=0, addr_err=0, wr_err=0, busy=0, burst_done=0, burst_len=0; state=IDLE; beat counter=0.
- FSM has two states:
  - IDLE: if load_signal=1, go to BURST; this cycle counts as beat 1.
  - BURST: while load_signal=1, stay and increment the beat counter. When load_signal=0, go to IDLE, pulse burst_done, load burst_len from the counter, and clear the counter.
- Beat counter: 5 bits, saturates at 31 and does not wrap.
- Read beat (load_signal=1): on the next cycle rd_valid=1 and rd_data=mem[mem_addr].
  - If mem_addr >= DEPTH: rd_data=0, addr_err=1, rd_valid=1. The beat still counts toward burst_len.
- Idle cycle (load_signal=0): rd_valid=0 and addr_err=0. rd_data holds its last value.
- Host write:
  - Accepted only when load_signal=0 and state=IDLE.
  - Writes with wr_addr >= DEPTH are dropped silently; wr_err stays 0.
  - A write attempted while load_signal=1 or state=BURST is dropped, and wr_err=1 on the next cycle.
- busy = (state==BURST). It is a registered output.

## Timing
- Read latency: 1 cycle. A beat sampled at edge N shows rd_data/rd_valid/addr_err after edge N, and they stay valid until edge N+1.
- Back-to-back beats: one response per cycle with no bubbles. Addresses may repeat or be in any order.
- Write to read: a write accepted at edge N is visible to a beat sampled at edge N+1 or later.
- A write and a load sampled in the same cycle cannot both succeed; the write is rejected per the rule above.
- burst_done: asserted for exactly one cycle after the edge that samples the first load_signal=0 following a burst. burst_len updates on that same edge.
- A burst can restart the cycle after it ends: load_signal 1,0,1 gives burst_done on the middle cycle's edge, and the new burst starts at count 1.
- Reset mid-burst (rst=1 with load_signal=1): reset wins. The block returns to IDLE with no burst_done pulse, and burst_len=0. The next cycle with load_signal=1 after rst falls starts a new burst.
- rst has priority over every other input on the same edge.

## Test plan
- Reset: assert rst for 2 cycles with load_signal=1 and wr_en=1, then read addresses 0..15 → every rd_data=0, no burst_done during reset, burst_len=0.
- Fill and stream: write mem[i]=8'hA0+i for i=0..15, then drive a 4-beat burst with addresses 0,1,2,3 → rd_valid high for 4 cycles with data A0,A1,A2,A3 one cycle behind each address; burst_done pulses once with burst_len=4; busy is high for 4 cycles.
- Out of range, DEPTH=12: burst with addresses 11,12,15 → rd_data=AB,00,00; addr_err=0,1,1; burst_len=3.
- Write collision: in the same cycle drive wr_en=1 to address 5 (data 8'h55) and load_signal=1 → wr_err=1 on the next cycle; a later read of address 5 returns the old value A5.
- Saturation and restart: hold load_signal high for 40 cycles → burst_len=31. Then drive load_signal pattern 1,0,1,1,0 → burst_len=1, then 2, with two separate burst_done pulses.
- Reset mid-burst: start a burst, assert rst after 3 beats → no burst_done, busy=0 and rd_valid=0 after the reset edge. A following 2-beat burst reports burst_len=2.
